// File: rtl/seq_counter_pkg.sv
// Shared control-unit constants for the sequence counter: default width,
// modulus and the terminal-count helper so every user agrees on N.
package seq_counter_pkg;

  localparam int SC_WIDTH   = 4;
  localparam int SC_MODULUS = 16;

  // Terminal value of a modulo-N count, i.e. the last legal state N-1.
  localparam int SC_TERMINAL = SC_MODULUS - 1;

  function automatic int sc_terminal(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/seq_counter_mod_onehot_decoder.sv
// Binary to one-hot decoder: out[k] is high when in equals k.
// Also used by the opcode decoder, so it carries no counter knowledge.
module onehot_decoder #(
  parameter int WIDTH = 4,
  parameter int OUTS  = 16
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUTS-1:0]  out
);

  // Compare the input against every output index.
  always_comb begin
    out = {OUTS{1'b0}};
    for (int k = 0; k < OUTS; k++) begin
      out[k] = (in == WIDTH'(k));
    end
  end

endmodule

// File: rtl/seq_counter_mod.sv
// Modulo-N up/down sequence counter with clear, load, one-hot T decode,
// terminal-count and wrap flags, and a sticky out-of-range-load error.
module seq_counter_mod
  import seq_counter_pkg::*;
#(
  parameter int WIDTH   = SC_WIDTH,
  parameter int MODULUS = SC_MODULUS
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic               LD,
  input  logic [WIDTH-1:0]   D,
  input  logic               INR,
  input  logic               DN,
  output logic [WIDTH-1:0]   SC,
  output logic [MODULUS-1:0] T,
  output logic               TC,
  output logic               WRAP,
  output logic               ERR
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(sc_terminal(MODULUS));
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] sc_r;
  logic             wrap_r;
  logic             err_r;

  logic [WIDTH-1:0] sc_next_s;
  logic             wrap_next_s;
  logic             err_next_s;
  logic             at_zero_s;
  logic             at_term_s;
  logic             d_oor_s;

  assign at_zero_s = (sc_r == ZERO);
  assign at_term_s = (sc_r == TERM);
  // Widen by one bit so a full-range modulus (TERM = all ones) compares cleanly.
  assign d_oor_s   = ({1'b0, D} > {1'b0, TERM});

  // Next-state priority mux: CLR > LD > INR > hold (RST handled in the register).
  always_comb begin
    sc_next_s   = sc_r;
    wrap_next_s = 1'b0;
    err_next_s  = err_r;
    if (CLR) begin
      sc_next_s = ZERO;
    end else if (LD) begin
      if (d_oor_s) begin
        sc_next_s  = TERM;
        err_next_s = 1'b1;
      end else begin
        sc_next_s = D;
      end
    end else if (INR) begin
      if (DN) begin
        if (at_zero_s) begin
          sc_next_s   = TERM;
          wrap_next_s = 1'b1;
        end else begin
          sc_next_s = sc_r - ONE;
        end
      end else begin
        if (at_term_s) begin
          sc_next_s   = ZERO;
          wrap_next_s = 1'b1;
        end else begin
          sc_next_s = sc_r + ONE;
        end
      end
    end else begin
      sc_next_s = sc_r;
    end
  end

  // Count and flag registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sc_r   <= ZERO;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      sc_r   <= sc_next_s;
      wrap_r <= wrap_next_s;
      err_r  <= err_next_s;
    end
  end

  onehot_decoder #(
    .WIDTH (WIDTH),
    .OUTS  (MODULUS)
  ) u_t_decode (
    .in  (sc_r),
    .out (T)
  );

  assign SC   = sc_r;
  assign WRAP = wrap_r;
  assign ERR  = err_r;
  assign TC   = INR & (DN ? at_zero_s : at_term_s);

endmodule

// File: tb/tb_seq_counter_mod.sv
// Bench for seq_counter_mod: a modulus-16 and a modulus-10 instance share
// inputs and are compared against a modular-arithmetic reference model.
module tb_seq_counter_mod;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CLR = 1'b0;
  logic       LD  = 1'b0;
  logic [3:0] D   = 4'd0;
  logic       INR = 1'b0;
  logic       DN  = 1'b0;

  logic [3:0]  sc16, sc10;
  logic [15:0] t16;
  logic [9:0]  t10;
  logic        tc16, tc10, wrap16, wrap10, err16, err10;

  int checks = 0;
  int errors = 0;

  int mod_n [2] = '{16, 10};
  int m_sc  [2];
  int m_wrap[2];
  int m_err [2];
  bit model_valid = 1'b0;

  always #5 CLK = ~CLK;

  seq_counter_mod #(.WIDTH(4), .MODULUS(16)) dut16 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .LD(LD), .D(D), .INR(INR), .DN(DN),
    .SC(sc16), .T(t16), .TC(tc16), .WRAP(wrap16), .ERR(err16)
  );

  seq_counter_mod #(.WIDTH(4), .MODULUS(10)) dut10 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .LD(LD), .D(D), .INR(INR), .DN(DN),
    .SC(sc10), .T(t10), .TC(tc10), .WRAP(wrap10), .ERR(err10)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one counter for one rising edge, in plain modular arithmetic.
  task automatic model_edge(input int i);
    int n;
    n = mod_n[i];
    if (RST) begin
      m_sc[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
    end else if (CLR) begin
      m_sc[i] = 0; m_wrap[i] = 0;
    end else if (LD) begin
      m_wrap[i] = 0;
      if (int'(D) < n) m_sc[i] = int'(D);
      else begin m_sc[i] = n - 1; m_err[i] = 1; end
    end else if (INR) begin
      m_wrap[i] = DN ? (m_sc[i] == 0) : (m_sc[i] == n - 1);
      m_sc[i]   = DN ? (m_sc[i] + n - 1) % n : (m_sc[i] + 1) % n;
    end else begin
      m_wrap[i] = 0;
    end
  endtask

  function automatic logic exp_tc(input int i);
    return INR && (DN ? (m_sc[i] == 0) : (m_sc[i] == mod_n[i] - 1));
  endfunction

  // Apply inputs for one cycle, check TC before the edge and registered outputs after.
  task automatic cycle(input logic rst, input logic clr, input logic ld,
                       input logic [3:0] d, input logic inr, input logic dn);
    RST = rst; CLR = clr; LD = ld; D = d; INR = inr; DN = dn;
    #1;
    if (model_valid) begin
      check_value("tc16", 32'(tc16), 32'(exp_tc(0)));
      check_value("tc10", 32'(tc10), 32'(exp_tc(1)));
    end
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    model_valid = 1'b1;
    #1;
    check_value("sc16",   32'(sc16),   32'(m_sc[0]));
    check_value("wrap16", 32'(wrap16), 32'(m_wrap[0]));
    check_value("err16",  32'(err16),  32'(m_err[0]));
    check_value("t16",    32'(t16),    32'(1) << m_sc[0]);
    check_value("sc10",   32'(sc10),   32'(m_sc[1]));
    check_value("wrap10", 32'(wrap10), 32'(m_wrap[1]));
    check_value("err10",  32'(err10),  32'(m_err[1]));
    check_value("t10",    32'(t10),    32'(1) << m_sc[1]);
    check_value("sc10_range", 32'(sc10 <= 4'd9), 32'd1);
  endtask

  initial begin
    @(negedge CLK);

    // Reset, then free run at defaults.
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check_value("rst_sc", 32'(sc16), 32'd0);
    check_value("rst_t",  32'(t16),  32'd1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      check_value("run_sc",   32'(sc16),   32'((i + 1) % 16));
      check_value("run_wrap", 32'(wrap16), 32'(i == 15));
    end

    // Non-power-of-two modulus counting up: 8, 9, 0.
    cycle(1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    check_value("m10_ld8", 32'(sc10), 32'd8);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check_value("m10_9", 32'(sc10), 32'd9);
    INR = 1'b1; DN = 1'b0; #1;
    check_value("m10_tc9", 32'(tc10), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check_value("m10_wrap0", 32'({sc10, wrap10}), 32'({4'd0, 1'b1}));

    // Down count from 1: 0, 9, 8 with WRAP alongside 9.
    cycle(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check_value("dn_0", 32'(sc10), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check_value("dn_9", 32'({sc10, wrap10}), 32'({4'd9, 1'b1}));
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check_value("dn_8", 32'({sc10, wrap10}), 32'({4'd8, 1'b0}));

    // Out-of-range load, CLR keeps ERR, RST clears it.
    cycle(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    check_value("oor_sc",  32'(sc10),  32'd9);
    check_value("oor_err", 32'(err10), 32'd1);
    check_value("oor16",   32'({sc16, err16}), 32'({4'd12, 1'b0}));
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check_value("clr_keep_err", 32'({sc10, err10}), 32'({4'd0, 1'b1}));
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check_value("rst_err", 32'(err10), 32'd0);

    // Priority collisions.
    cycle(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    check_value("clr_ld_inr", 32'(sc10), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
    check_value("clr_oor_noerr", 32'(err10), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
    check_value("ld_inr", 32'(sc10), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      check_value("hold", 32'({sc10, wrap10}), 32'({4'd5, 1'b0}));
    end

    // Reset mid-count with a competing load.
    cycle(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    check_value("rst_mid", 32'({sc10, wrap10, sc16, wrap16}), 32'({4'd0, 1'b0, 4'd0, 1'b0}));

    // Randomised traffic, mostly counting with occasional controls.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_counter_mod.md
# seq_counter_mod

Parametrised sequence counter for the processor control unit: a modulo-N up/down counter with synchronous clear, parallel load, increment enable, one-hot timing-signal decode (T0..T(N-1)) and wrap/terminal-count flags. It replaces the free-running 4-bit sequence counter. The control unit drives CLR at the end of each instruction, and the decoded T outputs sequence the micro-operations.

## Interface
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count length N; legal range 2..2^WIDTH. Counts span 0..N-1.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high; clears all state including ERR.
- CLR  input  1  synchronous clear of SC to 0; does not clear ERR.
- LD  input  1  synchronous parallel load of D.
- D  input  WIDTH  load value.
- INR  input  1  count enable; SC holds when low.
- DN  input  1  direction: 0 up, 1 down.
- SC  output  WIDTH  registered count.
- T  output  MODULUS  one-hot decode of SC; T[k] = (SC == k).
- TC  output  1  combinational terminal count: INR & (DN ? SC==0 : SC==N-1).
- WRAP  output  1  registered one-cycle pulse: the previous edge wrapped the count.
- ERR  output  1  sticky flag: an out-of-range load occurred.

## Operation
- Priority at each rising edge: RST > CLR > LD > INR > hold.
- RST: SC=0, WRAP=0, ERR=0.
- CLR: SC=0, WRAP=0. ERR unchanged.
- LD: if D <= N-1, SC=D. If D >= N, SC=N-1 and ERR=1. WRAP=0.
- INR, DN=0: SC==N-1 → SC=0 and WRAP=1. Otherwise SC+1 and WRAP=0.
- INR, DN=1: SC==0 → SC=N-1 and WRAP=1. Otherwise SC-1 and WRAP=0.
- Hold (no control asserted): SC unchanged, WRAP=0.
- Arithmetic is performed in WIDTH bits. Wrap compares against N-1, not 2^WIDTH-1, so non-power-of-two moduli never leave 0..N-1.
- Tying INR=1, DN=0, CLR=LD=0 with WIDTH=4, MODULUS=16 gives the legacy free-running sequence behaviour.
- Simultaneous CLR and LD: CLR wins and D is ignored. An out-of-range D does not set ERR.
- Simultaneous LD and INR: the load wins, and no count step is applied on that edge.
- RST asserted mid-count: SC is 0 on the following cycle regardless of other inputs.

## Timing
- SC, WRAP and ERR are registered and update on the CLK rising edge.
- T and TC are combinational from the SC register and inputs, with no added latency. T is valid in the same cycle as SC.
- Latency from a CLR, LD or INR request to the new SC: 1 cycle.
- WRAP is high for exactly the one cycle in which SC shows the wrapped value (0 up, N-1 down).
- TC is high in the cycle before the wrapping edge, so the control unit can use it as the last-T-state indicator.
- Reset values: SC=0, T=one-hot bit 0, WRAP=0, ERR=0, TC=INR & ~DN ? 0 : INR.

## Structure
- The shared control package holds:
  - SC_WIDTH and SC_MODULUS defaults, so the control unit and this block agree on N;
  - the localparam for the terminal value (N-1).
- One sub-module is natural: onehot_decoder (WIDTH in → MODULUS one-hot out), which is reused by the opcode decoder.
- The top level contains the priority mux, the modulo-step logic and the flag registers.

## Test plan
- Reset and free-run: RST for 2 cycles, then INR=1, DN=0 for 20 cycles at defaults. Required response:
  - SC sequence 0,1..15,0,1,2,3;
  - WRAP high only in the cycle SC=0 after 15;
  - T one-hot matching SC throughout.
- Non-power-of-two modulus: MODULUS=10, INR=1 up. Required response:
  - SC goes 8,9,0;
  - TC high at SC=9;
  - SC never reaches 10..15.
- Down count: MODULUS=10, LD D=1, then DN=1, INR=1. Required response: SC goes 1,0,9,8; WRAP pulses with SC=9.
- Out-of-range load: MODULUS=10, LD D=12. Required response:
  - SC=9, ERR=1;
  - a subsequent CLR gives SC=0 with ERR still 1;
  - RST clears ERR.
- Priority collisions:
  - CLR+LD(D=5)+INR → SC=0;
  - LD(D=5)+INR → SC=5;
  - INR=0 for 3 cycles → SC holds 5, WRAP=0.
- Reset mid-count: at SC=7 with INR=1, assert RST together with LD D=3. Required response: SC=0 next cycle and WRAP=0.
